// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store unit.
// Little-endian lanes: addr[1:0] picks the byte and addr[1] picks the halfword.
package lsu_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } lsu_state_e;

    // Replace the addressed byte or halfword of a RAM word with store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic        half,
                                               input logic [1:0]  off);
        logic [31:0] res;
        res = word;
        if (half) begin
            if (off[1]) res[31:16] = wdata[15:0];
            else        res[15:0]  = wdata[15:0];
        end else begin
            case (off)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end
        return res;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] res;
        byte_sh = word >> {off, 3'b000};
        half_sh = word >> {off[1], 4'b0000};
        case (funct3)
            MEM_B:   res = {{24{byte_sh[7]}}, byte_sh[7:0]};
            MEM_BU:  res = {24'd0, byte_sh[7:0]};
            MEM_H:   res = {{16{half_sh[15]}}, half_sh[15:0]};
            MEM_HU:  res = {16'd0, half_sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select with sign/zero extension; purely combinational, no latency.
// No state and no backpressure: output follows the RAM word in the same cycle.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    assign data = load_extend(rdata, funct3, off);

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage LSU: loads and SW in one cycle, SB/SH as read-modify-write in two.
// Backpressure: stall=1 only in the read cycle of SB/SH; faulted requests never touch the RAM.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int FAULT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [2:0]             funct3,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            load_data,
    output logic                   stall,
    output logic                   access_fault,
    output logic [FAULT_CNT_W-1:0] fault_count,
    output logic [ADDR_W-1:0]      data_memory_address,
    output logic [31:0]            data_memory_data_in,
    output logic                   store,
    output logic                   load,
    input  logic [31:0]            data_memory_data_out
);

    lsu_state_e        state;
    logic [31:0]       merge_q;
    logic [ADDR_W-1:0] addr_q;

    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        off;
    logic              illegal_f3;
    logic              misalign;
    logic              idle_req;
    logic              sub_store;
    logic [31:0]       aligned;

    // Upper address bits intentionally dropped: addresses wrap modulo RAM size.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, addr[31:ADDR_W+2]};

    assign word_addr  = addr[ADDR_W+1:2];
    assign off        = addr[1:0];
    assign illegal_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (req_we && funct3[2]);
    assign misalign   = ((funct3[1:0] == 2'b10) && (off != 2'b00)) ||
                        ((funct3[1:0] == 2'b01) && off[0]);
    assign idle_req   = !rst && (state == IDLE) && req_valid;
    assign sub_store  = req_we && !funct3[1];

    lsu_load_align u_load_align (
        .rdata  (data_memory_data_out),
        .funct3 (funct3),
        .off    (off),
        .data   (aligned)
    );

    always_comb begin
        load_data           = '0;
        stall               = 1'b0;
        access_fault        = 1'b0;
        data_memory_address = '0;
        data_memory_data_in = '0;
        store               = 1'b0;
        load                = 1'b0;
        if (idle_req) begin
            if (illegal_f3 || misalign) begin
                access_fault = 1'b1;
            end else if (req_we && sub_store) begin
                load                = 1'b1;
                stall               = 1'b1;
                data_memory_address = word_addr;
            end else if (req_we) begin
                store               = 1'b1;
                data_memory_address = word_addr;
                data_memory_data_in = wdata;
            end else begin
                load                = 1'b1;
                data_memory_address = word_addr;
                load_data           = aligned;
            end
        end else if (!rst && (state == RMW_WRITE)) begin
            store               = 1'b1;
            data_memory_address = addr_q;
            data_memory_data_in = merge_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            merge_q     <= '0;
            addr_q      <= '0;
            fault_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access_fault) begin
                        if (fault_count != {FAULT_CNT_W{1'b1}})
                            fault_count <= fault_count + 1'b1;
                    end else if (stall) begin
                        merge_q <= lane_merge(data_memory_data_out, wdata, funct3[0], off);
                        addr_q  <= word_addr;
                        state   <= RMW_WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a behavioural word RAM and an expected-value queue.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        access_fault;
    logic [7:0]  fault_count;
    logic [11:0] data_memory_address;
    logic [31:0] data_memory_data_in;
    logic        store;
    logic        load;
    logic [31:0] data_memory_data_out;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (store) mem[data_memory_address] <= data_memory_data_in;
    end
    assign data_memory_data_out = load ? mem[data_memory_address] : 32'hDEAD_BEEF;

    lsu_mem_stage #(.ADDR_W(12), .FAULT_CNT_W(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req_valid            (req_valid),
        .req_we               (req_we),
        .funct3               (funct3),
        .addr                 (addr),
        .wdata                (wdata),
        .load_data            (load_data),
        .stall                (stall),
        .access_fault         (access_fault),
        .fault_count          (fault_count),
        .data_memory_address  (data_memory_address),
        .data_memory_data_in  (data_memory_data_in),
        .store                (store),
        .load                 (load),
        .data_memory_data_out (data_memory_data_out)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_ctl(input string tag, input logic st, input logic ld,
                              input logic sl, input logic af);
        push({tag, "_store"}, {31'd0, st});
        push({tag, "_load"},  {31'd0, ld});
        push({tag, "_stall"}, {31'd0, sl});
        push({tag, "_fault"}, {31'd0, af});
    endtask

    task automatic observe_ctl();
        pop_chk({31'd0, store});
        pop_chk({31'd0, load});
        pop_chk({31'd0, stall});
        pop_chk({31'd0, access_fault});
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
    } flt_vec_t;

    ld_vec_t  ld_tab[8];
    flt_vec_t flt_tab[4];

    initial begin
        ld_tab[0] = '{3'b000, 32'h1EC, 32'hFFFF_FF80};
        ld_tab[1] = '{3'b100, 32'h1EC, 32'h0000_0080};
        ld_tab[2] = '{3'b001, 32'h1EE, 32'hFFFF_8001};
        ld_tab[3] = '{3'b101, 32'h1EE, 32'h0000_8001};
        ld_tab[4] = '{3'b000, 32'h1ED, 32'h0000_007F};
        ld_tab[5] = '{3'b001, 32'h1EC, 32'h0000_7F80};
        ld_tab[6] = '{3'b100, 32'h1EF, 32'h0000_0080};
        ld_tab[7] = '{3'b010, 32'h1EC, 32'h8001_7F80};
        flt_tab[0] = '{1'b0, 3'b010, 32'h1ED};
        flt_tab[1] = '{1'b1, 3'b001, 32'h1EF};
        flt_tab[2] = '{1'b0, 3'b011, 32'h1EC};
        flt_tab[3] = '{1'b1, 3'b100, 32'h1EC};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        next(); next();

        // Reset must mask a request that is present.
        drive(1'b1, 3'b010, 32'h1EC, 32'hFFFF_FFFF);
        expect_ctl("rst", 0, 0, 0, 0);
        push("rst_addr", 0); push("rst_din", 0); push("rst_ld", 0); push("rst_fc", 0);
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address}); pop_chk(data_memory_data_in);
        pop_chk(load_data); pop_chk({24'd0, fault_count});
        next();
        rst = 1'b0; req_valid = 1'b0;
        expect_ctl("idle", 0, 0, 0, 0); push("idle_addr", 0); push("idle_din", 0);
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address}); pop_chk(data_memory_data_in);
        next();

        drive(1'b1, 3'b010, 32'h1EC, 32'h1234_CDEF);
        expect_ctl("sw", 1, 0, 0, 0); push("sw_addr", 123); push("sw_din", 32'h1234_CDEF);
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address}); pop_chk(data_memory_data_in);
        next();

        drive(1'b0, 3'b010, 32'h1EC, 32'h0);
        expect_ctl("lw", 0, 1, 0, 0); push("lw_addr", 123); push("lw_data", 32'h1234_CDEF);
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address}); pop_chk(load_data);
        next();

        // SB: read cycle with stall, then the merged write from captured state.
        drive(1'b1, 3'b000, 32'h1ED, 32'h1234_56AA);
        expect_ctl("sb_rd", 0, 1, 1, 0); push("sb_rd_addr", 123);
        expect_ctl("sb_wr", 1, 0, 0, 0); push("sb_wr_addr", 123); push("sb_wr_din", 32'h1234_AAEF);
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address});
        next();
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address}); pop_chk(data_memory_data_in);
        next();

        drive(1'b0, 3'b010, 32'h1EC, 32'h0);
        push("sb_lw", 32'h1234_AAEF);
        settle();
        pop_chk(load_data);
        next();

        drive(1'b1, 3'b010, 32'h1EC, 32'h8001_7F80);
        expect_ctl("sw2", 1, 0, 0, 0);
        settle();
        observe_ctl();
        next();

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, ld_tab[i].f3, ld_tab[i].a, 32'h0);
            expect_ctl("ldx", 0, 1, 0, 0); push("ldx_data", ld_tab[i].exp);
            settle();
            observe_ctl(); pop_chk(load_data);
            next();
        end

        for (int i = 0; i < 4; i++) begin
            drive(flt_tab[i].we, flt_tab[i].f3, flt_tab[i].a, 32'h5A5A_5A5A);
            expect_ctl("flt", 0, 0, 0, 1); push("flt_ld", 0);
            settle();
            observe_ctl(); pop_chk(load_data);
            next();
            req_valid = 1'b0;
            push("flt_cnt", i + 1);
            settle();
            pop_chk({24'd0, fault_count});
            next();
        end
        push("flt_mem", 32'h8001_7F80);
        pop_chk(mem[123]);

        drive(1'b0, 3'b011, 32'h1EC, 32'h0);
        repeat (256) next();
        req_valid = 1'b0;
        push("sat_cnt", 32'hFF);
        settle();
        pop_chk({24'd0, fault_count});
        next();

        // SH whose write cycle is hit by reset, then a clean retry.
        drive(1'b1, 3'b010, 32'h3FFC, 32'hFFFF_FFFF);
        next();
        drive(1'b1, 3'b001, 32'h3FFE, 32'h0000_5555);
        expect_ctl("sh_rd", 0, 1, 1, 0); push("sh_rd_addr", 32'hFFF);
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address});
        next();
        rst = 1'b1;
        expect_ctl("sh_rst", 0, 0, 0, 0);
        settle();
        observe_ctl();
        next();
        rst = 1'b0; req_valid = 1'b0;
        push("sh_abort_mem", 32'hFFFF_FFFF); push("rst_cnt", 0);
        expect_ctl("post_rst", 0, 0, 0, 0);
        settle();
        pop_chk(mem[12'hFFF]); pop_chk({24'd0, fault_count}); observe_ctl();
        next();

        drive(1'b1, 3'b001, 32'h3FFE, 32'h0000_5555);
        expect_ctl("sh2_rd", 0, 1, 1, 0);
        expect_ctl("sh2_wr", 1, 0, 0, 0); push("sh2_addr", 32'hFFF); push("sh2_din", 32'h5555_FFFF);
        settle();
        observe_ctl();
        next();
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address}); pop_chk(data_memory_data_in);
        next();
        req_valid = 1'b0;
        push("sh2_mem", 32'h5555_FFFF);
        pop_chk(mem[12'hFFF]);
        next();

        drive(1'b1, 3'b010, 32'hFFFF_C000, 32'h0000_0001);
        expect_ctl("wrap", 1, 0, 0, 0); push("wrap_addr", 0);
        settle();
        observe_ctl(); pop_chk({20'd0, data_memory_address});
        next();
        drive(1'b0, 3'b010, 32'h0, 32'h0);
        push("wrap_lw", 32'h1);
        settle();
        pop_chk(load_data);
        next();
        req_valid = 1'b0;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
